// File: rtl/apb_master_bridge.sv
// APB3 requester bridging the core load/store bus onto NUM_SLAVES completers.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter logic [31:0] SLAVE_SPAN     = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     req,
  input  logic                     we,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  logic [31:0]           off;
  logic [31:0]           slot;
  logic                  hit;
  logic [NUM_SLAVES-1:0] dec;

  // addr below the window would wrap in off, so it is excluded explicitly
  assign off  = addr - BASE_ADDR;
  assign slot = off / SLAVE_SPAN;
  assign hit  = (addr >= BASE_ADDR) && (slot < 32'(NUM_SLAVES));

  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec[i] = (slot == 32'(i));
    end
  end

  logic        pready_sel;
  logic [31:0] prdata_sel;

  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        pready_sel = PREADY[i];
        prdata_sel = PRDATA[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // the ready cycle itself never accepts a request
        if (req && !ready_q) begin
          if (hit) begin
            state_d   = S_SETUP;
            psel_d    = dec;
            penable_d = 1'b0;
            pwrite_d  = we;
            paddr_d   = addr;
            pwdata_d  = wdata;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      S_ACCESS: begin
        if (pready_sel) begin
          state_d   = S_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          if (!pwrite_q) rdata_d = prdata_sel;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d   = S_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = 32'hDEAD_BEEF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= S_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PWDATA  = pwdata_q;
  assign PSEL    = psel_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: random core transfers against
// behavioural APB slaves and a transaction-level reference model.
module tb_apb_master_bridge;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;
  localparam int          TMO  = 16;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic            req, we;
  logic [31:0]     addr, wdata;
  logic [31:0]     rdata;
  logic            ready, err;
  logic [31:0]     PADDR;
  logic            PWRITE, PENABLE;
  logic [31:0]     PWDATA;
  logic [NS-1:0]   PSEL;
  logic [32*NS-1:0] PRDATA;
  logic [NS-1:0]   PREADY;

  apb_master_bridge #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE),
    .SLAVE_SPAN(SPAN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          start;
    logic [NS-1:0] psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          sl_idx = -1;
  int          sl_wait = 0;
  logic [31:0] sl_prdata = '0;
  logic [31:0] last_rd = '0;
  bit          pend_b2b = 0;
  logic [NS-1:0] prev_psel = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, want, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event seen, none required @%0t", nm, $time);
  endtask

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slaves: the addressed one raises PREADY after sl_wait ACCESS cycles,
  // everything else (including the SETUP cycle) is random noise.
  int acnt = 0;
  always @(negedge PCLK) begin
    if (sl_idx >= 0 && PSEL[sl_idx] && PENABLE) acnt++;
    else acnt = 0;
    for (int i = 0; i < NS; i++) begin
      if (i == sl_idx) begin
        PRDATA[32*i +: 32] = sl_prdata;
        if (PSEL[i] && PENABLE) PREADY[i] = (acnt > sl_wait);
        else PREADY[i] = 1'($urandom_range(0, 1));
      end else begin
        PRDATA[32*i +: 32] = $urandom;
        PREADY[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  always @(negedge PCLK) begin
    if (!PRESET) begin
      prev_psel = '0;
    end else begin
      if (PSEL != '0) begin
        if (exp_q.size() == 0) fail_now("psel_idle");
        else begin
          chk("psel", 32'(PSEL), 32'(exp_q[0].psel));
          chk("paddr", PADDR, exp_q[0].paddr);
          chk("pwrite", 32'(PWRITE), 32'(exp_q[0].pwrite));
          if (exp_q[0].pwrite) chk("pwdata", PWDATA, exp_q[0].pwdata);
          if (prev_psel == '0) chk("setup_pen", 32'(PENABLE), 32'd0);
        end
      end
      if (ready) begin
        if (exp_q.size() == 0) fail_now("spurious_ready");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", rdata, e.rdata);
          chk("latency", 32'(cyc - e.start), 32'(e.lat));
          done_cnt++;
        end
      end
      prev_psel = PSEL;
    end
  end

  task automatic present(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int wt,
                         input logic [31:0] prd);
    exp_t   e;
    longint ua = longint'(a);
    longint lo = longint'(BASE);
    longint hi = lo + longint'(NS) * longint'(SPAN);
    e.start  = cyc;
    e.psel   = '0;
    e.paddr  = a;
    e.pwrite = w;
    e.pwdata = d;
    if (ua >= lo && ua < hi) begin
      int idx = int'((ua - lo) / longint'(SPAN));
      e.psel    = NS'(1) << idx;
      sl_idx    = idx;
      sl_wait   = wt;
      sl_prdata = prd;
      e.err     = 1'b0;
      e.rdata   = w ? last_rd : prd;
      e.lat     = 3 + wt;
`ifdef APB_TIMEOUT_EN
      if (wt >= TMO) begin
        e.err   = 1'b1;
        e.rdata = 32'hDEAD_BEEF;
        e.lat   = 2 + TMO;
      end
`endif
    end else begin
      sl_idx  = -1;
      e.err   = 1'b1;
      e.rdata = '0;
      e.lat   = 1;
    end
    if (pend_b2b) e.lat++;
    last_rd = e.rdata;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic reset_recover();
    @(negedge PCLK);
    #2 PRESET = 1'b0;
    #1;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    req = 1'b0;
    exp_q.delete();
    sl_idx   = -1;
    last_rd  = '0;
    pend_b2b = 0;
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    @(negedge PCLK);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      #1;
      if (done_cnt != d0) return;
    end
    $display("FAIL done_timeout: no ready within %0d cycles", budget);
    n_chk++;
    n_fail++;
    reset_recover();
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int wt,
                      input logic [31:0] prd);
    present(w, a, d, wt, prd);
    wait_done(300);
  endtask

  // g == 0 keeps req high into the next transfer
  task automatic gap(input int g);
    pend_b2b = (g == 0);
    if (g > 0) begin
      req = 1'b0;
      repeat (g) begin
        @(negedge PCLK);
        #1;
      end
    end
  endtask

  initial begin
    PRESET = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    PRDATA = '0; PREADY = '0;
    repeat (2) @(negedge PCLK);
    #1;
    chk("r_psel", 32'(PSEL), 32'd0);
    chk("r_penable", 32'(PENABLE), 32'd0);
    chk("r_pwrite", 32'(PWRITE), 32'd0);
    chk("r_paddr", PADDR, 32'd0);
    chk("r_pwdata", PWDATA, 32'd0);
    chk("r_rdata", rdata, 32'd0);
    chk("r_ready", 32'(ready), 32'd0);
    chk("r_err", 32'(err), 32'd0);
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    @(negedge PCLK);
    #1;

    xfer(1'b1, 32'h1000_0008, 32'h0000_00A5, 1, $urandom);
    gap(1);
    xfer(1'b0, 32'h1000_2004, $urandom, 3, 32'h1234_5678);
    gap(2);
    xfer(1'b0, 32'h2000_0000, $urandom, 0, $urandom);
    gap(1);
    xfer(1'b1, 32'h1000_1010, $urandom, 0, $urandom);
    gap(0);
    xfer(1'b0, 32'h1000_3000, $urandom, 2, $urandom);
    gap(0);
    xfer(1'b0, BASE - 32'd1, $urandom, 0, $urandom);
    gap(0);
    xfer(1'b0, BASE + NS * SPAN, $urandom, 0, $urandom);
    gap(1);
    xfer(1'b0, BASE + NS * SPAN - 32'd1, $urandom, 1, $urandom);
    gap(1);
    xfer(1'b1, BASE, $urandom, 0, $urandom);
    gap(1);

    present(1'b0, 32'h1000_2000, $urandom, 50, $urandom);
    repeat (4) begin
      @(negedge PCLK);
      #1;
    end
    chk("pre_rst_pen", 32'(PENABLE), 32'd1);
    reset_recover();
    xfer(1'b0, 32'h1000_1004, $urandom, 1, 32'hCAFE_0001);
    gap(1);

`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 32'h1000_3000, $urandom, 1000, $urandom);
    gap(1);
    xfer(1'b0, 32'h1000_0000, $urandom, TMO - 1, 32'h0BAD_F00D);
    gap(1);
    xfer(1'b1, 32'h1000_2000, $urandom, TMO, $urandom);
    gap(1);
`else
    begin
      int d0;
      d0 = done_cnt;
      present(1'b0, 32'h1000_3000, $urandom, 1000000, $urandom);
      repeat (100) begin
        @(negedge PCLK);
        #1;
      end
      chk("no_tmo_done", 32'(done_cnt), 32'(d0));
      chk("no_tmo_pen", 32'(PENABLE), 32'd1);
      reset_recover();
    end
`endif

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0: a = $urandom_range(0, BASE - 32'd1);
        1: a = BASE + NS * SPAN + $urandom_range(0, 32'hFFFF);
        2: a = $urandom;
        default: a = BASE + $urandom_range(0, NS - 1) * SPAN
                     + $urandom_range(0, SPAN - 32'd1);
      endcase
      xfer(1'($urandom_range(0, 1)), a, $urandom,
           $urandom_range(0, 4), $urandom);
      gap($urandom_range(0, 2));
    end
    req = 1'b0;
    repeat (3) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
